// File: rtl/wash_pkg.sv
// Shared types and helpers for the wash programme sequencer.
package wash_pkg;

  localparam int SEC_W = 8;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_WASH   = 3'd1,
    PH_DRAIN1 = 3'd2,
    PH_RINSE  = 3'd3,
    PH_DRAIN2 = 3'd4,
    PH_SPIN   = 3'd5,
    PH_DONE   = 3'd6
  } phase_t;

  function automatic logic [SEC_W-1:0] phase_duration(
    input phase_t p,
    input int     wash_s,
    input int     drain_s,
    input int     rinse_s,
    input int     spin_s
  );
    logic [SEC_W-1:0] d;
    d = '0;
    case (p)
      PH_WASH:              d = SEC_W'(wash_s);
      PH_DRAIN1, PH_DRAIN2: d = SEC_W'(drain_s);
      PH_RINSE:             d = SEC_W'(rinse_s);
      PH_SPIN:              d = SEC_W'(spin_s);
      default:              d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/wash_cycle_sequencer_if.sv
// Control/status bundle between the interlock stage, the sequencer and the actuators.
// All signals are levels sampled on clk; there is no valid/ready handshake on this bundle.
interface wash_cycle_sequencer_if;
  logic       start;
  logic       motor_permit;
  logic       door_closed;
  logic       motor_run;
  logic       motor_dir;
  logic       drain_valve;
  logic [2:0] phase;   // mirrors the FSM state register
  logic       paused;
  logic       done;

  modport master (
    output start, motor_permit, door_closed,
    input  motor_run, motor_dir, drain_valve, phase, paused, done
  );

  modport slave (
    input  start, motor_permit, door_closed,
    output motor_run, motor_dir, drain_valve, phase, paused, done
  );
endinterface

// File: rtl/wash_tick_gen.sv
// Seconds prescaler: counts 0..TICK_DIV-1 while enabled, ticks on the wrap; clr restarts it.
module wash_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  // tick must not depend on clr: the sequencer derives clr from tick.
  assign tick = en && (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/wash_cycle_sequencer.sv
// Wash programme sequencer: WASH, DRAIN1, RINSE, DRAIN2, SPIN, DONE with pause-on-gating.
// Optional macro SEQ_ABORT_EN: a start edge while running aborts via a drain (or straight to IDLE).
module wash_cycle_sequencer
  import wash_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int WASH_S   = 30,
  parameter int DRAIN_S  = 10,
  parameter int RINSE_S  = 20,
  parameter int SPIN_S   = 15,
  parameter int REV_S    = 5
) (
  input logic                    clk,
  input logic                    rst,
  wash_cycle_sequencer_if.slave  bus
);

  phase_t           state, state_nxt, after;
  logic             start_s, start_q, start_edge;
  logic [SEC_W-1:0] sec_cnt, sec_nxt, dir_cnt, dir_cnt_nxt;
  logic             run_r, dir_r, drain_r, paused_r, done_r;
  logic             run_nxt, dir_nxt, drain_nxt, paused_nxt, done_nxt;
  logic             running, gate_ok, pause, tick_en, tick, presc_clr, enter;
`ifdef SEQ_ABORT_EN
  logic             aborted, aborted_nxt;
`endif

  assign start_edge = start_s & ~start_q;
  assign running    = (state == PH_WASH) || (state == PH_DRAIN1) || (state == PH_RINSE) ||
                      (state == PH_DRAIN2) || (state == PH_SPIN);
  assign pause      = running && !gate_ok;
  assign tick_en    = running && gate_ok;

  // Draining and spinning run without water, so only the door gates them.
  always_comb begin
    gate_ok = 1'b1;
    case (state)
      PH_WASH, PH_RINSE:              gate_ok = bus.motor_permit;
      PH_DRAIN1, PH_DRAIN2, PH_SPIN:  gate_ok = bus.door_closed;
      default:                        gate_ok = 1'b1;
    endcase
  end

  always_comb begin
    after = PH_IDLE;
    case (state)
      PH_WASH:   after = PH_DRAIN1;
      PH_DRAIN1: after = PH_RINSE;
      PH_RINSE:  after = PH_DRAIN2;
`ifdef SEQ_ABORT_EN
      PH_DRAIN2: after = aborted ? PH_IDLE : PH_SPIN;
`else
      PH_DRAIN2: after = PH_SPIN;
`endif
      PH_SPIN:   after = PH_DONE;
      default:   after = PH_IDLE;
    endcase
  end

  wash_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_comb begin
    state_nxt   = state;
    sec_nxt     = sec_cnt;
    dir_cnt_nxt = dir_cnt;
    dir_nxt     = dir_r;
    enter       = 1'b0;
    presc_clr   = 1'b0;
`ifdef SEQ_ABORT_EN
    aborted_nxt = aborted;
`endif
    case (state)
      PH_IDLE, PH_DONE: begin
        if (start_edge) begin
          state_nxt = PH_WASH;
          enter     = 1'b1;
`ifdef SEQ_ABORT_EN
          aborted_nxt = 1'b0;
`endif
        end
      end
      PH_WASH, PH_DRAIN1, PH_RINSE, PH_DRAIN2, PH_SPIN: begin
`ifdef SEQ_ABORT_EN
        if (start_edge) begin
          enter = 1'b1;
          if (state == PH_WASH || state == PH_RINSE) begin
            state_nxt   = PH_DRAIN2;
            aborted_nxt = 1'b1;
          end else begin
            state_nxt   = PH_IDLE;
            aborted_nxt = 1'b0;
          end
        end else
`endif
        if (tick) begin
          if (sec_cnt <= SEC_W'(1)) begin
            state_nxt = after;
            enter     = 1'b1;
`ifdef SEQ_ABORT_EN
            if (after == PH_IDLE) aborted_nxt = 1'b0;
`endif
          end else begin
            sec_nxt = sec_cnt - 1'b1;
            if (state == PH_WASH || state == PH_RINSE) begin
              if (dir_cnt <= SEC_W'(1)) begin
                dir_nxt     = ~dir_r;
                dir_cnt_nxt = SEC_W'(REV_S);
              end else begin
                dir_cnt_nxt = dir_cnt - 1'b1;
              end
            end
          end
        end
      end
      default: begin
        state_nxt = PH_IDLE;
        enter     = 1'b1;
      end
    endcase

    if (enter) begin
      sec_nxt     = phase_duration(state_nxt, WASH_S, DRAIN_S, RINSE_S, SPIN_S);
      dir_cnt_nxt = SEC_W'(REV_S);
      dir_nxt     = 1'b0;
      presc_clr   = 1'b1;
    end

    // Outputs are decoded from the next state so they line up with the phase register.
    paused_nxt = pause && !enter;
    run_nxt    = 1'b0;
    drain_nxt  = 1'b0;
    done_nxt   = 1'b0;
    case (state_nxt)
      PH_WASH, PH_RINSE: run_nxt = !paused_nxt;
      PH_DRAIN1, PH_DRAIN2: drain_nxt = 1'b1;
      PH_SPIN: begin
        drain_nxt = 1'b1;
        run_nxt   = !paused_nxt;
      end
      PH_DONE: done_nxt = 1'b1;
      default: ;
    endcase
    if (!(state_nxt == PH_WASH || state_nxt == PH_RINSE)) dir_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PH_IDLE;
      start_s  <= 1'b0;
      start_q  <= 1'b0;
      sec_cnt  <= '0;
      dir_cnt  <= '0;
      run_r    <= 1'b0;
      dir_r    <= 1'b0;
      drain_r  <= 1'b0;
      paused_r <= 1'b0;
      done_r   <= 1'b0;
`ifdef SEQ_ABORT_EN
      aborted  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      start_s  <= bus.start;
      start_q  <= start_s;
      sec_cnt  <= sec_nxt;
      dir_cnt  <= dir_cnt_nxt;
      run_r    <= run_nxt;
      dir_r    <= dir_nxt;
      drain_r  <= drain_nxt;
      paused_r <= paused_nxt;
      done_r   <= done_nxt;
`ifdef SEQ_ABORT_EN
      aborted  <= aborted_nxt;
`endif
    end
  end

  assign bus.phase       = state;
  assign bus.motor_run   = run_r;
  assign bus.motor_dir   = dir_r;
  assign bus.drain_valve = drain_r;
  assign bus.paused      = paused_r;
  assign bus.done        = done_r;

endmodule
